// File: rtl/piano_audio_pkg.sv
// Shared constants and types for the piano audio datapath.
package piano_audio_pkg;
  localparam int DATA_W   = 20;
  localparam int PERIOD_W = 24;

  localparam logic [DATA_W-1:0] AMPL    = 20'h3FFFF;
  localparam logic [DATA_W-1:0] SILENCE = 20'h00000;

  typedef enum logic [0:0] {
    WAIT_TICK = 1'b0,
    PUSH      = 1'b1
  } state_t;
endpackage

// File: rtl/sample_tick_div.sv
// Free-running sample-rate divider; tick is high for the last cycle of each period.
module sample_tick_div #(
  parameter int SAMPLE_DIV = 2834
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/tone_sample_gen.sv
// Square-wave tone synthesiser producing one PCM sample per sample period
// and handing it to the I2S FIFO, counting samples lost to a full FIFO.
module tone_sample_gen
  import piano_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 2834
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] tone_period,
  input  logic                tone_load,
  input  logic                note_on,
  input  logic [2:0]          volume,
  output logic [DATA_W-1:0]   i2s_din,
  output logic                i2s_wr_en,
  input  logic                i2s_full,
  output logic [15:0]         overrun_cnt,
  output logic                active
);
  localparam logic [PERIOD_W-1:0] DIV_P  = PERIOD_W'(SAMPLE_DIV);
  localparam logic [PERIOD_W:0]   DIV_PH = (PERIOD_W+1)'(SAMPLE_DIV);

  function automatic logic signed [DATA_W-1:0] scale_amp(input logic [2:0] sh);
    return $signed(AMPL >> sh);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                      tick;
  logic [PERIOD_W-1:0]       period;
  logic [PERIOD_W:0]         phase;
  logic [PERIOD_W:0]         phase_n;
  logic                      pol;
  logic                      silent;
  logic signed [DATA_W-1:0]  amp;
  logic signed [DATA_W-1:0]  sample_p0;
  logic signed [DATA_W-1:0]  hold_p1;
  state_t                    state;

  sample_tick_div #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    silent    = (period == '0) || (period < DIV_P) || !note_on;
    amp       = scale_amp(volume);
    phase_n   = phase + DIV_PH;
    sample_p0 = $signed(SILENCE);
    if (!silent) sample_p0 = pol ? amp : -amp;
  end

  // Oscillator state; a tone_load on the same edge as a tick overrides the phase update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= '0;
      phase  <= '0;
      pol    <= 1'b1;
    end else begin
      if (tick) begin
        if (silent) begin
          phase <= '0;
          pol   <= 1'b1;
        end else if (phase_n >= {1'b0, period}) begin
          phase <= phase_n - {1'b0, period};
          pol   <= ~pol;
        end else begin
          phase <= phase_n;
        end
      end
      if (tone_load) begin
        period <= tone_period;
        phase  <= '0;
        pol    <= 1'b1;
      end
    end
  end

  // ---- stage p1: held sample waiting for the FIFO ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_TICK;
      hold_p1     <= '0;
      overrun_cnt <= '0;
    end else begin
      case (state)
        WAIT_TICK: begin
          if (tick) begin
            hold_p1 <= sample_p0;
            state   <= PUSH;
          end
        end
        PUSH: begin
          if (tick) begin
            hold_p1 <= sample_p0;
            if (i2s_full) overrun_cnt <= sat_inc(overrun_cnt);
          end else if (!i2s_full) begin
            state <= WAIT_TICK;
          end
        end
        default: state <= WAIT_TICK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else      active <= (period != '0) && (period >= DIV_P) && note_on;
  end

  assign i2s_wr_en = (state == PUSH) && !i2s_full;
  assign i2s_din   = hold_p1;
endmodule
